// File: rtl/jtag_pkg.sv
// jtag_pkg: shared types and constants for the JTAG master engine.
//   jtag_op_e    - command opcodes as carried on cmd_op
//   jtag_state_e - engine sequencing states
//   pre_count()  - number of ticks spent in PRE for an opcode
//   pre_tms()    - TMS level for a given PRE tick
package jtag_pkg;

    typedef enum logic [1:0] {
        JTAG_TAP_RESET = 2'd0,
        JTAG_SHIFT_IR  = 2'd1,
        JTAG_SHIFT_DR  = 2'd2,
        JTAG_IDLE      = 2'd3
    } jtag_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_RESP
    } jtag_state_e;

    localparam int TAP_RESET_TMS_CNT = 5;
    localparam int DR_PRE_LEN        = 3;
    localparam int IR_PRE_LEN        = 4;
    localparam int POST_LEN          = 2;

    // TAP_RESET is run entirely in PRE: five TMS=1 ticks plus one TMS=0
    // tick that parks the TAP in Run-Test/Idle.
    function automatic int pre_count(jtag_op_e op);
        case (op)
            JTAG_TAP_RESET: return TAP_RESET_TMS_CNT + 1;
            JTAG_SHIFT_IR:  return IR_PRE_LEN;
            default:        return DR_PRE_LEN;
        endcase
    endfunction

    // Shift preambles are some TMS=1 ticks followed by exactly two TMS=0
    // ticks (Capture, Shift), so the ones occupy the first len-2 ticks.
    function automatic logic pre_tms(jtag_op_e op, int idx);
        case (op)
            JTAG_TAP_RESET: return idx < TAP_RESET_TMS_CNT;
            JTAG_SHIFT_IR:  return idx < (IR_PRE_LEN - 2);
            default:        return idx < (DR_PRE_LEN - 2);
        endcase
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK divider. While enable is high it produces one TCK period
// every 2*CLK_DIV sys_clk cycles: CLK_DIV cycles low, then CLK_DIV high.
//   sys_clk, sys_rst - clock and synchronous active-high reset
//   enable           - run the divider; low forces tck=0 and restarts the period
//   tck              - JTAG clock
//   fall             - first cycle of the low phase
//   sample           - last cycle of the high phase (TDO sample point)
//   tick_done        - last cycle of the period
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic enable,
    output logic tck,
    output logic fall,
    output logic sample,
    output logic tick_done
);

    localparam int PERIOD = 2 * CLK_DIV;
    localparam int CW     = $clog2(PERIOD);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !enable) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CW'(PERIOD - 1)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tck       = enable && (cnt_reg >= CW'(CLK_DIV));
    assign fall      = enable && (cnt_reg == '0);
    assign sample    = enable && (cnt_reg == CW'(PERIOD - 1));
    assign tick_done = sample;

endmodule

// File: rtl/jtag_master.sv
// jtag_master: command-driven JTAG master. Walks the TAP through reset, IR/DR
// shifts and idle clocks, and returns captured TDO on a response channel.
//   sys_clk, sys_rst            - clock and synchronous active-high reset
//   cmd_valid/ready/op/len/data - command channel (data shifted LSB first)
//   rsp_valid/ready/data/err    - response channel, held until rsp_ready
//   tap_known                   - TAP known to be in Run-Test/Idle
//   tck, tms, tdi, tdo          - JTAG pins
module jtag_master
    import jtag_pkg::*;
#(
    parameter  int MAX_LEN = 32,
    parameter  int CLK_DIV = 2,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               tap_known,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    // Tick counter must cover both shift lengths and the 6-tick reset walk.
    localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    jtag_state_e        state_reg, state_next;
    jtag_op_e           op_reg;
    jtag_op_e           cmd_op_e;
    logic [LEN_W-1:0]   len_reg;
    logic [MAX_LEN-1:0] data_reg;
    logic [MAX_LEN-1:0] cap_reg;
    logic [CNT_W-1:0]   tick_reg;
    logic [CNT_W-1:0]   phase_end;
    logic [IDX_W-1:0]   bit_idx;
    logic               err_reg, known_reg, live_reg;
    logic               tms_reg, tdi_reg, tms_next, tdi_next;
    logic               tck_en, fall_stb, sample_stb, tick_done;
    logic               accept, cmd_bad, phase_last;

    assign cmd_op_e = jtag_op_e'(cmd_op);
    assign bit_idx  = tick_reg[IDX_W-1:0];
    assign accept   = cmd_valid && cmd_ready;

    // Shifts need a known TAP; TAP_RESET is always accepted.
    assign cmd_bad = (cmd_op_e != JTAG_TAP_RESET) &&
                     ((cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN)) ||
                      ((cmd_op_e != JTAG_IDLE) && !known_reg));

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .enable    (tck_en),
        .tck       (tck),
        .fall      (fall_stb),
        .sample    (sample_stb),
        .tick_done (tick_done)
    );

    assign tck_en = (state_reg == ST_PRE) || (state_reg == ST_SHIFT) ||
                    (state_reg == ST_POST);

    // Index of the final tick in the current phase.
    always_comb begin
        phase_end = CNT_W'(POST_LEN - 1);
        case (state_reg)
            ST_PRE:   phase_end = CNT_W'(pre_count(op_reg) - 1);
            ST_SHIFT: phase_end = CNT_W'(len_reg) - CNT_W'(1);
            default:  phase_end = CNT_W'(POST_LEN - 1);
        endcase
        phase_last = (tick_reg == phase_end);
    end

    // Next state and the pin levels wanted for the current tick.
    always_comb begin
        state_next = state_reg;
        tms_next   = 1'b0;
        tdi_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_bad)
                        state_next = ST_RESP;
                    else if (cmd_op_e == JTAG_IDLE)
                        state_next = ST_SHIFT;
                    else
                        state_next = ST_PRE;
                end
            end
            ST_PRE: begin
                tms_next = pre_tms(op_reg, int'(tick_reg));
                if (tick_done && phase_last)
                    state_next = (op_reg == JTAG_TAP_RESET) ? ST_RESP : ST_SHIFT;
            end
            ST_SHIFT: begin
                // Idle clocks reuse SHIFT with TMS and TDI held low.
                tms_next = (op_reg != JTAG_IDLE) && phase_last;
                tdi_next = (op_reg != JTAG_IDLE) && data_reg[bit_idx];
                if (tick_done && phase_last)
                    state_next = (op_reg == JTAG_IDLE) ? ST_RESP : ST_POST;
            end
            ST_POST: begin
                tms_next = (tick_reg == '0);
                if (tick_done && phase_last)
                    state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pins only change on the first low-phase cycle and hold otherwise.
    assign tms = fall_stb ? tms_next : tms_reg;
    assign tdi = fall_stb ? tdi_next : tdi_reg;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= JTAG_TAP_RESET;
            len_reg   <= '0;
            data_reg  <= '0;
            cap_reg   <= '0;
            tick_reg  <= '0;
            err_reg   <= 1'b0;
            known_reg <= 1'b0;
            live_reg  <= 1'b0;
            tms_reg   <= 1'b0;
            tdi_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            live_reg  <= 1'b1;
            tms_reg   <= tms;
            tdi_reg   <= tdi;
            if (accept) begin
                op_reg   <= cmd_op_e;
                len_reg  <= cmd_len;
                data_reg <= cmd_data;
                tick_reg <= '0;
                err_reg  <= cmd_bad;
            end
            if (tick_done)
                tick_reg <= phase_last ? '0 : tick_reg + 1'b1;
            if (sample_stb && (state_reg == ST_SHIFT) && (op_reg != JTAG_IDLE))
                cap_reg[bit_idx] <= tdo;
            if ((state_reg == ST_PRE) && (op_reg == JTAG_TAP_RESET) &&
                tick_done && phase_last)
                known_reg <= 1'b1;
            if ((state_reg == ST_RESP) && rsp_ready) begin
                cap_reg <= '0;
                err_reg <= 1'b0;
            end
        end
    end

    assign cmd_ready = live_reg && (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_data  = cap_reg;
    assign rsp_err   = err_reg;
    assign tap_known = known_reg;

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: directed plus randomized checks of jtag_master against a
// tick-level reference model of the TAP walk (TMS/TDI per tick, latency,
// captured data, error flag).
module tb_jtag_master;

    localparam int MAX_LEN = 32;
    localparam int CLK_DIV = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int TICK    = 2 * CLK_DIV;
    localparam int HIST    = 8192;

    logic               sys_clk   = 1'b0;
    logic               sys_rst   = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               rsp_ready = 1'b0;
    logic [1:0]         cmd_op    = 2'd0;
    logic [LEN_W-1:0]   cmd_len   = '0;
    logic [MAX_LEN-1:0] cmd_data  = '0;
    logic               cmd_ready, rsp_valid, rsp_err, tap_known;
    logic [MAX_LEN-1:0] rsp_data;
    logic               tck, tms, tdi, tdo;

    int   total = 0;
    int   bad   = 0;
    logic tk    = 1'b0;
    int   tdo_mode = 0;
    logic loop_cap = 1'b0;
    logic loop_reg = 1'b0;
    logic rnd_tdo  = 1'b0;
    int   mon_n    = 0;
    logic tms_hist [HIST];
    logic tdi_hist [HIST];
    logic tdo_hist [HIST];

    jtag_master #(
        .MAX_LEN (MAX_LEN),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .tap_known (tap_known),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    always #5 sys_clk = ~sys_clk;

    // Target side: records each tick's pins at the rising TCK edge; TDO is
    // updated just after the falling edge, like a real TAP.
    always @(posedge tck) begin
        tms_hist[mon_n % HIST] = tms;
        tdi_hist[mon_n % HIST] = tdi;
        tdo_hist[mon_n % HIST] = tdo;
        loop_cap = tdi;
        mon_n++;
    end

    always @(negedge tck) begin
        #1;
        loop_reg = loop_cap;
        rnd_tdo  = 1'($urandom_range(0, 1));
    end

    assign tdo = (tdo_mode == 1) ? loop_reg : (tdo_mode == 2) ? 1'b1 : rnd_tdo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input int len, input logic [31:0] data,
                           input int hold, input string tag, output logic [31:0] got);
        logic        err_e, steady;
        int          n_e, pre, lat, base, waited, seen;
        logic [63:0] tms_e, tdi_e, tms_o, tdi_o;
        logic [31:0] rsp_e;

        // Reference model: expected tick sequence from the TAP walk rules.
        err_e = (op != 2'd0) && ((len == 0) || (len > MAX_LEN) || ((op != 2'd3) && !tk));
        tms_e = '0;
        tdi_e = '0;
        n_e   = 0;
        pre   = 0;
        if (!err_e) begin
            case (op)
                2'd0: begin
                    n_e = 6;
                    tms_e[4:0] = 5'b11111;
                end
                2'd3: n_e = len;
                default: begin
                    pre = (op == 2'd1) ? 4 : 3;
                    tms_e[0] = 1'b1;
                    if (op == 2'd1) tms_e[1] = 1'b1;
                    for (int i = 0; i < len; i++) tdi_e[pre + i] = data[i];
                    tms_e[pre + len - 1] = 1'b1;
                    tms_e[pre + len]     = 1'b1;
                    n_e = pre + len + 2;
                end
            endcase
        end

        base = mon_n;
        @(negedge sys_clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge sys_clk);
            waited++;
        end
        chk({tag, ".accept"}, 64'(cmd_ready), 64'd1);
        @(posedge sys_clk);
        #1 cmd_valid = 1'b0;

        lat = 0;
        do begin
            @(negedge sys_clk);
            lat++;
        end while (!rsp_valid && lat < 4000);

        seen  = mon_n - base;
        tms_o = '0;
        tdi_o = '0;
        for (int k = 0; k < seen && k < 64; k++) begin
            tms_o[k] = tms_hist[(base + k) % HIST];
            tdi_o[k] = tdi_hist[(base + k) % HIST];
        end
        rsp_e = '0;
        if (!err_e && (op == 2'd1 || op == 2'd2))
            for (int i = 0; i < len; i++) rsp_e[i] = tdo_hist[(base + pre + i) % HIST];
        if (!err_e && op == 2'd0) tk = 1'b1;

        chk({tag, ".latency"}, 64'(lat), 64'(err_e ? 1 : n_e * TICK + 1));
        chk({tag, ".ticks"}, 64'(seen), 64'(n_e));
        chk({tag, ".tms"}, tms_o, tms_e);
        chk({tag, ".tdi"}, tdi_o, tdi_e);
        chk({tag, ".err"}, 64'(rsp_err), 64'(err_e));
        chk({tag, ".data"}, 64'(rsp_data), 64'(rsp_e));
        chk({tag, ".busy"}, 64'(cmd_ready), 64'd0);
        chk({tag, ".known"}, 64'(tap_known), 64'(tk));
        got = rsp_data;

        steady = 1'b1;
        repeat (hold) begin
            @(negedge sys_clk);
            if (!(rsp_valid === 1'b1 && cmd_ready === 1'b0 && rsp_data === rsp_e &&
                  rsp_err === err_e && tck === 1'b0))
                steady = 1'b0;
        end
        if (hold > 0) chk({tag, ".hold"}, 64'(steady), 64'd1);

        @(negedge sys_clk);
        rsp_ready = 1'b1;
        @(posedge sys_clk);
        #1 rsp_ready = 1'b0;
        @(negedge sys_clk);
        chk({tag, ".clear"}, {31'd0, rsp_valid, rsp_err, rsp_data}, 64'd0);
        chk({tag, ".ready"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] got, d;
        int          n, op, w;

        // Reset state.
        repeat (3) @(negedge sys_clk);
        chk("rst.ready_in_reset", 64'(cmd_ready), 64'd0);
        chk("rst.tck_in_reset", 64'(tck), 64'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst.ready", 64'(cmd_ready), 64'd1);
        chk("rst.pins", {61'd0, tck, tms, tdi}, 64'd0);
        chk("rst.rsp", {30'd0, rsp_valid, rsp_err, rsp_data}, 64'd0);
        chk("rst.known", 64'(tap_known), 64'd0);

        // Shift before the TAP is known is rejected.
        run_cmd(2'd2, 8, 32'h38, 0, "dr_unknown", got);

        run_cmd(2'd0, 0, 32'h0, 0, "tap_reset", got);

        // Loopback through a 1-bit register: capture is data delayed by one.
        tdo_mode = 1;
        run_cmd(2'd2, 8, 32'h38, 0, "dr_loop", got);
        chk("dr_loop.value", 64'(got), 64'h70);

        tdo_mode = 2;
        run_cmd(2'd1, 5, $urandom, 0, "ir_ones", got);
        chk("ir_ones.value", 64'(got), 64'h1F);

        tdo_mode = 0;
        run_cmd(2'd3, MAX_LEN, $urandom, 0, "idle_max", got);
        run_cmd(2'd2, MAX_LEN + 1, $urandom, 10, "dr_too_long", got);
        run_cmd(2'd2, 0, $urandom, 0, "dr_zero", got);
        run_cmd(2'd2, 1, 32'h1, 0, "dr_len1", got);
        run_cmd(2'd1, MAX_LEN, $urandom, 2, "ir_max", got);

        for (int r = 0; r < 10; r++) begin
            op = $urandom_range(1, 3);
            n  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, MAX_LEN);
            d  = $urandom;
            run_cmd(2'(op), n, d, $urandom_range(0, 3), "rand", got);
        end

        // Reset in the middle of tick 4 of a DR shift.
        @(negedge sys_clk);
        n = mon_n;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_len   = LEN_W'(8);
        cmd_data  = $urandom;
        @(posedge sys_clk);
        #1 cmd_valid = 1'b0;
        w = 0;
        while ((mon_n - n) < 5 && w < 200) begin
            @(negedge sys_clk);
            w++;
        end
        chk("abort.reached", 64'(mon_n - n), 64'd5);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        tk = 1'b0;
        chk("abort.pins", {61'd0, tck, tms, tdi}, 64'd0);
        chk("abort.state", {61'd0, tap_known, rsp_valid, cmd_ready}, 64'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("abort.ready", 64'(cmd_ready), 64'd1);
        run_cmd(2'd2, 4, $urandom, 0, "after_abort", got);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- Parametrised JTAG master engine clocked from sys_clk. It generates tck/tms/tdi and samples tdo, and sits opposite the jtag_dpi TAP model/bridge.
- It accepts commands on a valid/ready interface: TAP reset, IR shift, DR shift, idle clocks.
- It walks the IEEE 1149.1 TAP state sequence itself and returns the captured TDO bits on a valid/ready response channel.
- It generalises the fixed bit-bang pins to variable shift length, programmable TCK rate and error reporting.

Parameters:
- MAX_LEN, 32, maximum shift/idle length in bits; also the width of cmd_data/rsp_data.
- CLK_DIV, 2, sys_clk cycles per TCK half-period (>=2). TCK period = 2*CLK_DIV sys_clk cycles.
- LEN_W, $clog2(MAX_LEN+1), width of cmd_len (derived localparam, not overridable).

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  engine accepts a command.
- cmd_op  in  2  0=TAP_RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=IDLE.
- cmd_len  in  LEN_W  bit count for SHIFT_*/IDLE; ignored for TAP_RESET.
- cmd_data  in  MAX_LEN  TDI bits, shifted LSB first.
- rsp_valid  out  1  response valid; held until rsp_ready.
- rsp_ready  in  1  response accepted.
- rsp_data  out  MAX_LEN  captured TDO, LSB = first bit; bits >= len are zero.
- rsp_err  out  1  command rejected, no TCK activity.
- tap_known  out  1  TAP is known to be in Run-Test/Idle.
- tck  out  1  JTAG clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data in.
- tdo  in  1  JTAG data out from the target.

Behaviour:
- Reset values: tck=0, tms=0, tdi=0, cmd_ready=0 in the reset cycle then 1, rsp_valid=0, rsp_data=0, rsp_err=0, tap_known=0.
- Reset mid-command aborts immediately; tck returns to 0 without finishing the period.
- Tick: one TCK period.
  - Low phase: CLK_DIV cycles. tms/tdi update on the first cycle of the low phase.
  - High phase: CLK_DIV cycles. tdo is sampled on the last cycle of the high phase.
  - tck idles at 0 between commands.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready=0 from acceptance until the response handshake (rsp_valid && rsp_ready) completes.
  - No pipelining: one outstanding command.
- FSM states: IDLE, PRE, SHIFT, POST, RESP.
  - TAP_RESET: 5 ticks with tms=1, then 1 tick with tms=0 (6 ticks total). Sets tap_known=1.
  - SHIFT_DR:
    - PRE sends tms 1,0,0 (Select-DR, Capture-DR, Shift-DR).
    - SHIFT sends N ticks: tdi=cmd_data[i] on tick i; tms=0 except tms=1 on the last tick (Exit1). tdo is sampled into rsp_data[i].
    - POST sends tms 1,0 (Update, Run-Test/Idle).
    - Total N+5 ticks.
  - SHIFT_IR: PRE sends tms 1,1,0,0, then identical to SHIFT_DR. Total N+6 ticks.
  - IDLE: N ticks with tms=0 and tdi=0. rsp_data=0.
  - tdi=0 outside the SHIFT state.
- Errors: a SHIFT_*/IDLE command is rejected when any of the following holds:
  - cmd_len==0
  - cmd_len>MAX_LEN
  - SHIFT_* issued while tap_known=0

  On rejection, rsp_valid rises the cycle after acceptance with rsp_err=1 and rsp_data=0, and no tck edges occur. TAP_RESET is never rejected.
- rsp_valid rises the cycle after the final high phase ends. rsp_data and rsp_err are stable while rsp_valid=1 and are cleared on the handshake.
- A 1-bit shift (N=1) has tms=1 on its only shift tick.
- A command with cmd_len=MAX_LEN fills all rsp_data bits.

Decomposition:
- Package jtag_pkg:
  - op enum: JTAG_TAP_RESET, JTAG_SHIFT_IR, JTAG_SHIFT_DR, JTAG_IDLE.
  - FSM state enum.
  - Constants: TAP_RESET_TMS_CNT=5, DR_PRE_LEN=3, IR_PRE_LEN=4, POST_LEN=2.
- Sub-module jtag_tck_gen(CLK_DIV):
  - Inputs: enable.
  - Outputs: tck, a fall strobe at the start of the low phase, a sample strobe at the last high cycle, and a tick_done strobe.
  - Divider counter reset by sys_rst or by enable=0.
- The main FSM, tick counter, and TDI/TDO shift registers live in jtag_master.

Test Plan:
- Reset, then SHIFT_DR len=8 -> rsp_err=1 and rsp_data=0 one cycle after acceptance; zero tck edges; tap_known=0.
- TAP_RESET with CLK_DIV=2 -> tms sequence 1,1,1,1,1,0 over 6 ticks (24 cycles); tap_known=1; rsp_err=0.
- SHIFT_DR len=8, cmd_data=8'h38, target loops tdi->tdo through a 1-bit register -> 13 ticks (52 cycles); tdi sequence on shift ticks 0,0,0,1,1,1,0,0; tms 1,0,0,0*7,1,1,0; rsp_data=8'h70 when the target register is preset to 0.
- SHIFT_IR len=5 with tdo tied 1 -> 11 ticks; rsp_data=32'h1F; upper bits zero.
- IDLE len=MAX_LEN=32 -> 32 ticks with tms=0; then SHIFT_DR len=33 -> rsp_err=1; rsp_ready held low for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0.
- sys_rst asserted during tick 4 of a SHIFT_DR -> next cycle tck=0, tms=0, tap_known=0, rsp_valid=0, cmd_ready=0; cmd_ready=1 one cycle after reset releases.
